// File: rtl/seq_1010110_tx.sv
// Serial frame transmitter for the 1010110 sync-detect link.
// A payload word accepted over a valid/ready handshake goes out on tx_out as
// the sync word, then the payload (both MSB-first), then an optional idle gap.
module seq_1010110_tx #(
   parameter int                DATA_W       = 8,
   parameter int                SYNC_W       = 7,
   parameter logic [SYNC_W-1:0] SYNC         = 7'b1010110,
   parameter int                CLKS_PER_BIT = 1,
   parameter int                GAP_BITS     = 1,
   parameter logic              IDLE_LEVEL   = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              tx_out,
   output logic              tx_active,
   output logic              sync_phase,
   output logic              frame_done
);

   // Counter sizing: each counter holds 0..max and is never narrower than 1 bit.
   localparam int CLK_MAX  = CLKS_PER_BIT - 1;
   localparam int CLK_W    = (CLK_MAX < 1) ? 1 : $clog2(CLK_MAX + 1);
   localparam int GAP_LAST = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;
   localparam int BIT_MAX0 = (SYNC_W > DATA_W) ? SYNC_W - 1 : DATA_W - 1;
   localparam int BIT_MAX  = (GAP_LAST > BIT_MAX0) ? GAP_LAST : BIT_MAX0;
   localparam int BIT_W    = (BIT_MAX < 1) ? 1 : $clog2(BIT_MAX + 1);

   typedef enum logic [1:0] {
      IDLE,
      SYNC_ST,
      DATA,
      GAP
   } state_t;

   state_t              state, state_n;
   logic [CLK_W-1:0]    clk_cnt, clk_cnt_n;
   logic [BIT_W-1:0]    bit_cnt, bit_cnt_n;
   logic [DATA_W-1:0]   shreg, shreg_n;
   logic                tx_out_n, tx_active_n, sync_phase_n, frame_done_n;
   logic                last_clk;
   logic                sync_bit;

   // Ready is a pure state decode so a word can be taken on any IDLE edge.
   assign data_ready = (state == IDLE);
   assign last_clk   = (clk_cnt == CLK_W'(CLK_MAX));

   // Next-state logic; outputs are derived from the next-state values so they
   // can be registered and still line up with the bit being sent.
   always_comb begin
      state_n   = state;
      clk_cnt_n = clk_cnt;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      case (state)
         IDLE: begin
            if (data_valid) begin
               state_n   = SYNC_ST;
               clk_cnt_n = '0;
               bit_cnt_n = '0;
               shreg_n   = data_in;
            end
         end
         SYNC_ST: begin
            if (last_clk) begin
               clk_cnt_n = '0;
               if (bit_cnt == BIT_W'(SYNC_W - 1)) begin
                  state_n   = DATA;
                  bit_cnt_n = '0;
               end else begin
                  bit_cnt_n = bit_cnt + BIT_W'(1);
               end
            end else begin
               clk_cnt_n = clk_cnt + CLK_W'(1);
            end
         end
         DATA: begin
            if (last_clk) begin
               clk_cnt_n = '0;
               if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                  state_n   = (GAP_BITS > 0) ? GAP : IDLE;
                  bit_cnt_n = '0;
                  shreg_n   = '0;
               end else begin
                  bit_cnt_n = bit_cnt + BIT_W'(1);
                  shreg_n   = shreg << 1;
               end
            end else begin
               clk_cnt_n = clk_cnt + CLK_W'(1);
            end
         end
         GAP: begin
            if (last_clk) begin
               clk_cnt_n = '0;
               if (bit_cnt == BIT_W'(GAP_LAST)) begin
                  state_n   = IDLE;
                  bit_cnt_n = '0;
               end else begin
                  bit_cnt_n = bit_cnt + BIT_W'(1);
               end
            end else begin
               clk_cnt_n = clk_cnt + CLK_W'(1);
            end
         end
         default: begin
            state_n   = IDLE;
            clk_cnt_n = '0;
            bit_cnt_n = '0;
            shreg_n   = '0;
         end
      endcase
   end

   // Select the sync bit for the upcoming bit position, MSB first.
   always_comb begin
      sync_bit = 1'b0;
      for (int i = 0; i < SYNC_W; i++) begin
         if (bit_cnt_n == BIT_W'(SYNC_W - 1 - i)) begin
            sync_bit = SYNC[i];
         end
      end
   end

   // Output values for the cycle after the coming edge.
   always_comb begin
      tx_out_n     = IDLE_LEVEL;
      tx_active_n  = 1'b0;
      sync_phase_n = 1'b0;
      frame_done_n = 1'b0;
      case (state_n)
         SYNC_ST: begin
            tx_out_n     = sync_bit;
            tx_active_n  = 1'b1;
            sync_phase_n = 1'b1;
         end
         DATA: begin
            tx_out_n     = shreg_n[DATA_W-1];
            tx_active_n  = 1'b1;
            frame_done_n = (bit_cnt_n == BIT_W'(DATA_W - 1)) &&
                           (clk_cnt_n == CLK_W'(CLK_MAX));
         end
         default: begin
            tx_out_n = IDLE_LEVEL;
         end
      endcase
   end

   // State, counters, payload and registered outputs; reset aborts any frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         clk_cnt    <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         tx_out     <= IDLE_LEVEL;
         tx_active  <= 1'b0;
         sync_phase <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         clk_cnt    <= clk_cnt_n;
         bit_cnt    <= bit_cnt_n;
         shreg      <= shreg_n;
         tx_out     <= tx_out_n;
         tx_active  <= tx_active_n;
         sync_phase <= sync_phase_n;
         frame_done <= frame_done_n;
      end
   end

endmodule

// File: tb/tb_seq_1010110_tx.sv
// Testbench for seq_1010110_tx: three instances (defaults, 3 clocks per bit,
// no gap) driven with directed frames; expected outputs come from hand-written
// frame bit patterns and the frame timing.
module tb_seq_1010110_tx;

   logic       clk;
   logic       reset_v      [3];
   logic [7:0] data_in_v    [3];
   logic       data_valid_v [3];
   logic       data_ready_v [3];
   logic       tx_out_v     [3];
   logic       tx_active_v  [3];
   logic       sync_phase_v [3];
   logic       frame_done_v [3];

   int tests;
   int fails;

   typedef struct {
      logic [7:0]  word;
      logic [14:0] bits;
      string       name;
   } vec_t;

   vec_t vecs [4];

   seq_1010110_tx u_dut0 (
      .clk(clk), .reset(reset_v[0]), .data_in(data_in_v[0]),
      .data_valid(data_valid_v[0]), .data_ready(data_ready_v[0]),
      .tx_out(tx_out_v[0]), .tx_active(tx_active_v[0]),
      .sync_phase(sync_phase_v[0]), .frame_done(frame_done_v[0])
   );

   seq_1010110_tx #(.CLKS_PER_BIT(3)) u_dut1 (
      .clk(clk), .reset(reset_v[1]), .data_in(data_in_v[1]),
      .data_valid(data_valid_v[1]), .data_ready(data_ready_v[1]),
      .tx_out(tx_out_v[1]), .tx_active(tx_active_v[1]),
      .sync_phase(sync_phase_v[1]), .frame_done(frame_done_v[1])
   );

   seq_1010110_tx #(.GAP_BITS(0)) u_dut2 (
      .clk(clk), .reset(reset_v[2]), .data_in(data_in_v[2]),
      .data_valid(data_valid_v[2]), .data_ready(data_ready_v[2]),
      .tx_out(tx_out_v[2]), .tx_active(tx_active_v[2]),
      .sync_phase(sync_phase_v[2]), .frame_done(frame_done_v[2])
   );

   // 10-unit clock; inputs change and outputs are sampled on the falling edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {tx_out, tx_active, sync_phase, frame_done, data_ready} for
   // cycle c (1 = first cycle after acceptance) of a 15-bit frame.
   function automatic logic [4:0] expVec(input logic [14:0] bits, input int cpb,
                                         input int gap, input int c);
      int total;
      int b;
      total = 15 * cpb;
      if (c <= total) begin
         b = (c - 1) / cpb;
         return {bits[14-b], 1'b1, (b < 7), (c == total), 1'b0};
      end else if (c <= total + gap * cpb) begin
         return 5'b00000;
      end
      return 5'b00001;
   endfunction

   task automatic checkOutput(input int k, input logic [4:0] expv,
                              input string name, input int c);
      logic [4:0] act;
      act = {tx_out_v[k], tx_active_v[k], sync_phase_v[k], frame_done_v[k],
             data_ready_v[k]};
      tests++;
      if (act !== expv) begin
         fails++;
         $display("[TB] FAIL %s dut%0d cycle %0d: got {tx,act,sync,done,rdy}=%b expected %b",
                  name, k, c, act, expv);
      end
   endtask

   // Offer one word for a single cycle; returns in cycle 1 of the frame.
   task automatic applyStimulus(input int k, input logic [7:0] w);
      data_in_v[k]    = w;
      data_valid_v[k] = 1'b1;
      @(negedge clk);
      data_valid_v[k] = 1'b0;
   endtask

   // Check every cycle of a frame up to and including the first ready cycle.
   task automatic checkFrame(input int k, input logic [14:0] bits, input int cpb,
                             input int gap, input string name);
      int len;
      len = 15 * cpb + gap * cpb + 1;
      for (int c = 1; c <= len; c++) begin
         if (c > 1) @(negedge clk);
         checkOutput(k, expVec(bits, cpb, gap, c), name, c);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      vecs[0] = '{8'hA5, 15'b1010110_10100101, "frame_a5"};
      vecs[1] = '{8'h00, 15'b1010110_00000000, "frame_00"};
      vecs[2] = '{8'h3C, 15'b1010110_00111100, "frame_3c"};
      vecs[3] = '{8'hC3, 15'b1010110_11000011, "frame_c3"};

      for (int k = 0; k < 3; k++) begin
         reset_v[k]      = 1'b1;
         data_in_v[k]    = 8'h00;
         data_valid_v[k] = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) checkOutput(k, 5'b00001, "reset_state", 0);
      for (int k = 0; k < 3; k++) reset_v[k] = 1'b0;

      // Table of single frames back to back on the default instance.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, vecs[i].word);
         checkFrame(0, vecs[i].bits, 1, 1, vecs[i].name);
      end

      // Valid held high: second word latched at acceptance despite later change.
      data_in_v[0]    = 8'h01;
      data_valid_v[0] = 1'b1;
      @(negedge clk);
      data_in_v[0] = 8'h02;
      checkFrame(0, 15'b1010110_00000001, 1, 1, "held_01");
      @(negedge clk);
      data_in_v[0] = 8'hFF;
      checkFrame(0, 15'b1010110_00000010, 1, 1, "held_02");
      data_valid_v[0] = 1'b0;
      @(negedge clk);
      checkOutput(0, 5'b00001, "stay_idle", 0);

      // Reset in cycle 10 aborts the frame with no frame_done.
      applyStimulus(0, 8'h5A);
      for (int c = 1; c <= 10; c++) begin
         if (c > 1) @(negedge clk);
         checkOutput(0, expVec(15'b1010110_01011010, 1, 1, c), "pre_abort", c);
      end
      reset_v[0] = 1'b1;
      @(negedge clk);
      reset_v[0] = 1'b0;
      for (int c = 11; c <= 17; c++) begin
         if (c > 11) @(negedge clk);
         checkOutput(0, 5'b00001, "aborted", c);
      end
      applyStimulus(0, 8'h3C);
      checkFrame(0, 15'b1010110_00111100, 1, 1, "after_abort");

      // Three clocks per bit.
      applyStimulus(1, 8'hFF);
      checkFrame(1, 15'b1010110_11111111, 3, 1, "cpb3_ff");

      // No gap, valid held high: 16-cycle period with a single IDLE cycle.
      data_in_v[2]    = 8'h81;
      data_valid_v[2] = 1'b1;
      @(negedge clk);
      data_in_v[2] = 8'h7E;
      checkFrame(2, 15'b1010110_10000001, 1, 0, "gap0_81");
      @(negedge clk);
      checkFrame(2, 15'b1010110_01111110, 1, 0, "gap0_7e");
      data_valid_v[2] = 1'b0;
      @(negedge clk);
      checkOutput(2, 5'b00001, "gap0_idle", 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
